// File: rtl/apu_rr_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FP unit among NUM_REQ requesters.
// Granted IDs queue in an in-order FIFO so each result returns to the requester that issued it.
module apu_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int OP_WIDTH     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*OP_WIDTH-1:0]     op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   opa_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   opb_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   opc_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           result_o,
    output logic                            unit_req_o,
    input  logic                            unit_gnt_i,
    output logic [OP_WIDTH-1:0]             unit_op_o,
    output logic [DATA_WIDTH-1:0]           unit_opa_o,
    output logic [DATA_WIDTH-1:0]           unit_opb_o,
    output logic [DATA_WIDTH-1:0]           unit_opc_o,
    input  logic                            unit_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           unit_result_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_INFLIGHT);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_fifo [MAX_INFLIGHT];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_rr_next;
    logic [IDW-1:0] w_head;
    logic [NUM_REQ-1:0] w_head_oh;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_orphan;
    logic [CW-1:0]  w_count_next;

    // Two passes: requesters at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_i[k] && (IDW'(k) >= r_rr_ptr)) begin
                w_found  = 1'b1;
                w_winner = IDW'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_i[k] && (IDW'(k) < r_rr_ptr)) begin
                w_found  = 1'b1;
                w_winner = IDW'(k);
            end
        end
    end

    always_comb begin
        unit_op_o  = '0;
        unit_opa_o = '0;
        unit_opb_o = '0;
        unit_opc_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_found && (w_winner == IDW'(k))) begin
                unit_op_o  = op_i[k*OP_WIDTH +: OP_WIDTH];
                unit_opa_o = opa_i[k*DATA_WIDTH +: DATA_WIDTH];
                unit_opb_o = opb_i[k*DATA_WIDTH +: DATA_WIDTH];
                unit_opc_o = opc_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Full blocks issue outright; a same-cycle pop does not free a slot until next cycle.
    assign w_full     = (r_count == CW'(MAX_INFLIGHT));
    assign unit_req_o = w_found && !w_full && !rst_i;
    assign w_push     = unit_req_o && unit_gnt_i;
    assign w_orphan   = unit_rvalid_i && (r_count == '0);
    assign w_pop      = unit_rvalid_i && (r_count != '0);
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_rr_next  = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        gnt_o     = '0;
        w_head_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_o[k]     = w_push && (w_winner == IDW'(k));
            w_head_oh[k] = (w_head == IDW'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_fifo[r_wr_ptr] <= w_winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            rvalid_o <= '0;
            result_o <= '0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                result_o <= unit_result_i;
            end
            rvalid_o <= w_pop ? w_head_oh : '0;
            r_count  <= w_count_next;
            busy_o   <= (w_count_next != '0);
            if (w_orphan) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/apu_rr_arbiter.md
Name: apu_rr_arbiter

Overview:
- Shares one pipelined APU floating-point unit (ADD/SUB/MULT/MAC/DIV/SQRT/ITF/FTI) among NUM_REQ core-side requesters.
- Round-robin arbitration on issue; each granted requester ID is recorded in an in-order in-flight FIFO.
- Each result is routed back to the requester that issued it.
- Sits between core APU interfaces and a single apu_package FP unit inside the APU cluster.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OP_WIDTH, 4, width of operation code (C_OP_* encodings)
DATA_WIDTH, 32, operand/result width
MAX_INFLIGHT, 4, in-flight ID FIFO depth (power of two, 2..16)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
req_i  in  NUM_REQ  per-requester request, held with operands until granted
op_i  in  NUM_REQ*OP_WIDTH  per-requester operation, slice k = requester k
opa_i  in  NUM_REQ*DATA_WIDTH  operand A per requester
opb_i  in  NUM_REQ*DATA_WIDTH  operand B per requester
opc_i  in  NUM_REQ*DATA_WIDTH  operand C per requester (MAC only)
gnt_o  out  NUM_REQ  one-hot grant, combinational
rvalid_o  out  NUM_REQ  one-hot result valid, registered
result_o  out  DATA_WIDTH  result, registered, shared by all requesters
unit_req_o  out  1  issue request to FP unit, combinational
unit_gnt_i  in  1  FP unit accepts issue this cycle
unit_op_o  out  OP_WIDTH  muxed operation
unit_opa_o / unit_opb_o / unit_opc_o  out  DATA_WIDTH each  muxed operands
unit_rvalid_i  in  1  FP unit result valid, in issue order
unit_result_i  in  DATA_WIDTH  FP unit result
busy_o  out  1  registered; 1 when the in-flight FIFO is non-empty
err_o  out  1  sticky; unit_rvalid_i seen with the FIFO empty

Behaviour:
- Reset: when rst_i=1 at a clock edge:
  - RR pointer=0; FIFO rd/wr pointers=0; count=0.
  - rvalid_o=0, result_o=0, busy_o=0, err_o=0.
  - gnt_o and unit_req_o are 0 while rst_i=1.
  - Reset mid-operation drops all in-flight IDs. Any later orphan unit_rvalid_i sets err_o. The FP unit shares rst_i, so this does not occur in-system.
- Arbitration (combinational):
  - Winner = first asserted req_i at or after the RR pointer, searching upward with wrap from NUM_REQ-1 to 0.
  - unit_req_o = |req_i & !full.
  - unit_op/opa/opb/opc_o = winner's slices. They are 0 when there is no winner.
  - gnt_o[winner] = unit_req_o & unit_gnt_i. At most one bit is set.
- Issue (clock edge with a grant):
  - Push winner ID into the FIFO.
  - RR pointer = (winner+1) mod NUM_REQ.
  - The RR pointer is unchanged on cycles with no grant.
- Full: count==MAX_INFLIGHT blocks issue (unit_req_o=0) even if a pop happens in the same cycle. There is no same-cycle pass-through.
- Return:
  - unit_rvalid_i=1 with count>0: pop head ID h. Next cycle rvalid_o = one-hot(h) and result_o = unit_result_i. Latency is 1 cycle.
  - rvalid_o is a single-cycle pulse per result. result_o holds its value until the next result.
- Simultaneous push and pop (count<MAX_INFLIGHT): both happen and count is unchanged.
- Empty return: unit_rvalid_i=1 with count==0 sets err_o (sticky until reset). rvalid_o stays 0 and result_o is unchanged.
- Counters and pointers: count width clog2(MAX_INFLIGHT)+1. rd/wr pointers wrap modulo MAX_INFLIGHT.
- busy_o = (count_next != 0), registered.
- Requesters must not drop req_i before gnt_o. Behaviour is undefined if they do, but the arbiter must stay consistent: no grant means no push.

Test Plan:
- Single issue: NUM_REQ=4, only req_i=4'b0100, op=C_OP_ADD, opa=0x3F800000, opb=0x40000000, unit_gnt_i=1 -> gnt_o=4'b0100 in the same cycle. Unit returns 0x40400000 three cycles later -> the next cycle rvalid_o=4'b0100, result_o=0x40400000.
- Round-robin fairness: all req_i=1111 held, unit_gnt_i=1, unit returns after 2 cycles -> grant sequence req0,1,2,3,0; each rvalid_o matches its issue order.
- Full back-pressure: MAX_INFLIGHT=4, unit withholds rvalid -> 4 grants then unit_req_o=0 and gnt_o=0. One rvalid -> the next cycle exactly one new grant; a pop during the full cycle does not grant that cycle.
- Unit stall: req_i=0010, unit_gnt_i=0 for 5 cycles -> gnt_o=0, RR pointer and FIFO unchanged. unit_gnt_i=1 -> single grant to requester 1.
- Simultaneous push/pop: count=2 with concurrent grant and unit_rvalid_i -> count stays 2, busy_o=1, correct requester receives result.
- Reset/error: reset with 3 in flight -> busy_o=0, rvalid_o=0. Subsequent unit_rvalid_i -> err_o=1 sticky, rvalid_o stays 0. Next rst_i clears err_o.
